simple_nco: RTL and testbench



---
 rtl/simple_nco.sv | 74 +++++++
 tb/tb_simple_nco.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_nco.sv
// Per-voice NCO: wavetable address advancing once every div_q cycles, wrapping at 2^ADDR_W.
// Optional macro SIMPLE_NCO_RESYNC_EN restarts the prescaler whenever the divider changes.
module simple_nco #(
   parameter int unsigned D_W    = 16,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [D_W-1:0]    nco_div,
   output logic [ADDR_W-1:0] nco_addr,
   output logic              nco_step,
   output logic              nco_wrap
);

   logic [D_W-1:0]    div_q;
   logic [D_W-1:0]    cnt;
   logic [D_W-1:0]    cnt_d;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_d;
   logic              step_q;
   logic              step_d;
   logic              wrap_q;
   logic              wrap_d;
   logic              resync;

   always_comb begin
`ifdef SIMPLE_NCO_RESYNC_EN
      resync = (nco_div != div_q);
`else
      resync = 1'b0;
`endif
   end

   // >= rather than == so a divider drop below the current count steps at once.
   always_comb begin
      cnt_d  = cnt;
      addr_d = addr;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (resync) begin
         cnt_d = '0;
      end else if (div_q == '0) begin
         cnt_d = '0;
      end else if (cnt >= div_q - D_W'(1)) begin
         cnt_d  = '0;
         addr_d = addr + ADDR_W'(1);
         step_d = 1'b1;
         wrap_d = (addr == '1);
      end else begin
         cnt_d = cnt + D_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_q  <= '0;
         cnt    <= '0;
         addr   <= '0;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         div_q  <= nco_div;
         cnt    <= cnt_d;
         addr   <= addr_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign nco_addr = addr;
   assign nco_step = step_q;
   assign nco_wrap = wrap_q;

endmodule

// File: tb/tb_simple_nco.sv
// Self-checking bench for simple_nco: cycle model feeding a scoreboard queue plus directed timing checks.
module tb_simple_nco;

   localparam int unsigned D_W    = 16;
   localparam int unsigned ADDR_W = 8;

   logic              sys_clk   = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic [D_W-1:0]    nco_div   = '0;
   logic [ADDR_W-1:0] nco_addr;
   logic              nco_step;
   logic              nco_wrap;

   simple_nco #(
      .D_W    (D_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .nco_div   (nco_div),
      .nco_addr  (nco_addr),
      .nco_step  (nco_step),
      .nco_wrap  (nco_wrap)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              step;
      logic              wrap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   int   m_div  = 0;
   int   m_cnt  = 0;
   int   m_addr = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Predict the next edge from the model, push it, clock, then compare.
   task automatic tick();
      exp_t e;
      bit   rs;
      rs = 1'b0;
`ifdef SIMPLE_NCO_RESYNC_EN
      rs = (int'(nco_div) != m_div);
`endif
      e = '0;
      if (rs || m_div == 0) begin
         m_cnt = 0;
      end else if (m_cnt + 1 >= m_div) begin
         e.step = 1'b1;
         e.wrap = (m_addr == (1 << ADDR_W) - 1);
         m_addr = (m_addr + 1) % (1 << ADDR_W);
         m_cnt  = 0;
      end else begin
         m_cnt = m_cnt + 1;
      end
      m_div  = int'(nco_div);
      e.addr = ADDR_W'(m_addr);
      exp_q.push_back(e);
      @(posedge sys_clk);
      #1;
      edge_n++;
      e = exp_q.pop_front();
      check("addr", 32'(nco_addr), 32'(e.addr));
      check("step", 32'(nco_step), 32'(e.step));
      check("wrap", 32'(nco_wrap), 32'(e.wrap));
   endtask

   // Asynchronous assert between edges, immediate check, release on the falling edge.
   task automatic apply_reset();
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("rst_addr", 32'(nco_addr), 32'd0);
      check("rst_step", 32'(nco_step), 32'd0);
      check("rst_wrap", 32'(nco_wrap), 32'd0);
      m_div  = 0;
      m_cnt  = 0;
      m_addr = 0;
      exp_q.delete();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      edge_n    = 0;
   endtask

   initial begin
      int first;
      int second;
      int steps;
      int wait_n;
      int base;

      // Halted from reset.
      nco_div = '0;
      apply_reset();
      steps = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (nco_step) steps++;
      end
      check("halt_addr", 32'(nco_addr), 32'd0);
      check("halt_steps", 32'(steps), 32'd0);

      // Divider 4: address 1 at edge 5, 2 at edge 9.
      nco_div = 16'd4;
      apply_reset();
      first  = 0;
      second = 0;
      steps  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (nco_step) steps++;
         if (nco_addr == 8'd1 && first == 0) first = edge_n;
         if (nco_addr == 8'd2 && second == 0) second = edge_n;
      end
      check("div4_first", 32'(first), 32'd5);
      check("div4_second", 32'(second), 32'd9);
      check("div4_steps", 32'(steps), 32'd2);

      // Divider 1: wraps at edges 257 and 513.
      nco_div = 16'd1;
      apply_reset();
      first  = 0;
      second = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (nco_wrap && first == 0) first = edge_n;
         else if (nco_wrap && second == 0) second = edge_n;
      end
      check("div1_wrap1", 32'(first), 32'd257);
      check("div1_wrap2", 32'(second), 32'd513);

      // Divider drop 1000 -> 10 at cnt 600, from a non-zero address.
      nco_div = 16'd5;
      apply_reset();
      for (int i = 0; i < 20; i++) tick();
      check("pre_addr", 32'(nco_addr), 32'd3);
      nco_div = 16'd1000;
      wait_n  = 0;
      while (m_cnt != 600 && wait_n < 2000) begin
         tick();
         wait_n++;
      end
      check("cnt600_reached", 32'(m_cnt), 32'd600);
      base    = int'(nco_addr);
      nco_div = 16'd10;
      wait_n  = 0;
      do begin
         tick();
         wait_n++;
         if (nco_addr != ADDR_W'(base) && !nco_step) break;
      end while (!nco_step && wait_n < 50);
`ifdef SIMPLE_NCO_RESYNC_EN
      check("drop_latency", 32'(wait_n), 32'd11);
`else
      check("drop_latency", 32'(wait_n), 32'd2);
`endif
      check("drop_addr", 32'(nco_addr), 32'(base + 1));

      // Halt at address 37, resume at 8.
      nco_div = 16'd8;
      apply_reset();
      wait_n = 0;
      while (!(nco_addr == 8'd37 && nco_step) && wait_n < 400) begin
         tick();
         wait_n++;
      end
      check("reach37_edge", 32'(edge_n), 32'd297);
      nco_div = '0;
      steps   = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (nco_step) steps++;
      end
      check("halted_addr", 32'(nco_addr), 32'd37);
      check("halted_steps", 32'(steps), 32'd0);
      nco_div = 16'd8;
      wait_n  = 0;
      do begin
         tick();
         wait_n++;
      end while (nco_addr == 8'd37 && wait_n < 50);
      check("resume_latency", 32'(wait_n), 32'd9);
      check("resume_addr", 32'(nco_addr), 32'd38);

      // Mid-run asynchronous reset with step high, then restart.
      nco_div = 16'd1;
      apply_reset();
      for (int i = 0; i < 10; i++) tick();
      check("pre_rst_addr", 32'(nco_addr), 32'd9);
      check("pre_rst_step", 32'(nco_step), 32'd1);
      apply_reset();
      first = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (nco_step && first == 0) first = edge_n;
      end
      check("restart_first", 32'(first), 32'd2);
      check("restart_addr", 32'(nco_addr), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
